// File: rtl/rtc_bus_arb_mux.sv
// N-channel RTC bus arbiter with grant hold, registered output mux and hold-timeout.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module rtc_bus_arb_mux #(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*WIDTH-1:0] data_in,
    output logic [N_CH-1:0]       grant,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  timeout
);

    localparam int IW = $clog2(N_CH);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IW-1:0] LAST_CH  = IW'(N_CH - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state, state_n;
    logic [N_CH-1:0]   grant_n, mask, mask_n, cand;
    logic [WIDTH-1:0]  data_n;
    logic              valid_n, timeout_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [IW-1:0]     owner, owner_n, win;

    // owner survives release, so it also serves as last_owner for round-robin
    always_comb begin
        cand = req & ~mask;
        win  = '0;
`ifdef ARB_ROUND_ROBIN_EN
        begin
            logic          found;
            logic [IW:0]   sum;
            logic [IW-1:0] idx;
            found = 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                sum = {1'b0, owner} + (IW+1)'(1) + (IW+1)'(i);
                if (sum >= (IW+1)'(N_CH))
                    sum = sum - (IW+1)'(N_CH);
                idx = IW'(sum);
                if (!found && cand[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
`else
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (cand[IW'(N_CH - 1 - i)])
                win = IW'(N_CH - 1 - i);
        end
`endif
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        data_n    = out_data;
        valid_n   = out_valid;
        timeout_n = 1'b0;
        cnt_n     = cnt;
        mask_n    = mask;
        owner_n   = owner;
        case (state)
            IDLE: begin
                mask_n  = '0;
                grant_n = '0;
                data_n  = '0;
                valid_n = 1'b0;
                if (cand != '0) begin
                    state_n = OWNED;
                    grant_n = N_CH'(1) << win;
                    data_n  = data_in[int'(win)*WIDTH +: WIDTH];
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    owner_n = win;
                end
            end
            OWNED: begin
                if (!req[owner]) begin
                    state_n = IDLE;
                    grant_n = '0;
                    data_n  = '0;
                    valid_n = 1'b0;
                end else if ((MAX_HOLD != 0) && (cnt == CNT_LAST)) begin
                    state_n   = IDLE;
                    grant_n   = '0;
                    data_n    = '0;
                    valid_n   = 1'b0;
                    timeout_n = 1'b1;
                    mask_n    = grant;
                end else begin
                    data_n = data_in[int'(owner)*WIDTH +: WIDTH];
                    if (cnt != '1)
                        cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= '0;
            mask      <= '0;
            owner     <= LAST_CH;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            timeout   <= timeout_n;
            cnt       <= cnt_n;
            mask      <= mask_n;
            owner     <= owner_n;
        end
    end

endmodule

// File: doc/rtc_bus_arb_mux.md
Name: rtc_bus_arb_mux

Overview:
- Parametrised successor to the two-channel bus selector in the RTC controller.
- Arbitrates N requesters for the shared RTC address/data bus and grants exactly one owner.
- Holds the grant for the owner's whole transaction and drives a registered bus output.
- Sits between the read/write/init sequencers and the RTC bus driver; a hold-timeout prevents one sequencer from locking the bus.

Parameters:
N_CH, 4, number of requesting channels (2..8)
WIDTH, 8, data width per channel
MAX_HOLD, 16, max consecutive OWNED cycles per grant; 0 = timeout disabled

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  N_CH  per-channel bus request, level, held for the whole transaction
data_in  in  N_CH*WIDTH  flat channel data; channel k = bits [k*WIDTH +: WIDTH]
grant  out  N_CH  one-hot owner, registered; all-zero when idle
out_data  out  WIDTH  registered data of the owner; 0 when idle
out_valid  out  1  high while a channel owns the bus
timeout  out  1  one-cycle pulse when a grant is forcibly released

Behaviour:
- Reset (async assert, sync deassert by design upstream): state=IDLE, grant=0, out_data=0, out_valid=0, timeout=0, hold counter=0, mask=0.
- States: IDLE, OWNED.
- IDLE:
  - cand = req & ~mask.
  - If cand!=0: at the next edge, state<=OWNED, grant<=one-hot of winner, out_data<=data_in[winner], out_valid<=1, counter<=0, mask<=0.
  - If cand==0: mask<=0 and stay IDLE, outputs 0.
  - Arbitration latency is 1 cycle.
- Winner selection: fixed priority, lowest index wins (ch0 highest), matching the two-channel selector's ch0 precedence.
- OWNED, owner req=1, no timeout:
  - out_data<=data_in[owner] every edge, so data tracks with 1-cycle latency.
  - counter increments.
  - Other requests are ignored; there is no preemption.
- OWNED, owner req=0 sampled at an edge:
  - state<=IDLE, grant<=0, out_valid<=0, out_data<=0.
  - There is always at least one IDLE cycle between owners (bus turnaround).
- Timeout:
  - If MAX_HOLD!=0, owner req=1 and counter==MAX_HOLD-1 at an edge: state<=IDLE, outputs cleared as above, timeout<=1 for one cycle, mask<=one-hot of owner.
  - The masked channel is excluded from the next arbitration only.
  - A grant therefore lasts at most MAX_HOLD cycles of out_valid.
- Counter width is clog2(MAX_HOLD+1) and it never wraps; it saturates and is unused when MAX_HOLD=0.
- Simultaneous release and timeout in the same cycle: release wins; no timeout pulse and no mask.
- Reset mid-grant: all outputs are 0 immediately (async); arbitration restarts from IDLE after reset_n rises.
- X/unused: bits of req above N_CH do not exist. Selecting a channel never reads outside data_in.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: winner is the first requesting channel at or after (last_owner+1) mod N_CH, searching upward with wrap.
  - last_owner resets to N_CH-1, so the first arbitration after reset is fixed-priority.
  - last_owner updates on each grant.
  - The timeout mask still applies.
- Undefined: fixed priority as above; no last_owner register is synthesised.

Test Plan:
- Reset, then req=4'b0110 with data ch1=8'hA1, ch2=8'hB2 -> one cycle later grant=4'b0010, out_data=8'hA1, out_valid=1; ch2 waits.
- Owner ch1 changes data 8'hA1->8'h5C while holding req -> out_data=8'h5C one cycle later; grant unchanged; req[0] rising meanwhile does not preempt.
- ch1 drops req while ch2 still requests -> one cycle with grant=0, out_valid=0, out_data=0; then grant=4'b0100, out_data=8'hB2.
- MAX_HOLD=16, ch0 holds req for 40 cycles, ch3 also requesting -> out_valid high exactly 16 cycles, timeout pulses once, next grant=4'b1000 (ch0 masked), then ch0 regains the bus after ch3 releases.
- Assert reset_n=0 mid-grant for half a cycle -> grant, out_valid, out_data go to 0 without a clock edge; after release with req=4'b0001 -> grant=4'b0001 after 1 cycle.
- With ARB_ROUND_ROBIN_EN, req=4'b1111 held, each owner releases after 2 cycles -> grant order ch0, ch1, ch2, ch3, ch0.
